seq_alu: RTL and testbench
==========================

Name: seq_alu

Overview:
- Parametrised, registered successor to the combinational datapath ALU.
- Generalises data width and adds a valid/ready handshake, a persistent ZCFNL flag register, true carry-in for ADDC, correct subtract/compare flags and variable-amount shifts.
- Shifts run iteratively, one bit per cycle.
- Sits between the register-file read stage and the writeback stage of the CPU pipeline.

Parameters:
- WIDTH, 16: data width in bits; must be ≥4 and a power of two.
- SHW, $clog2(WIDTH): width of the shift-amount field, taken from b[SHW-1:0].

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand/op presented.
- in_ready  output  1  block can accept an operation this cycle.
- op  input  4  opcode (values in alu_pkg).
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B, or shift amount.
- out_valid  output  1  result/flags valid.
- out_ready  input  1  consumer accepts result.
- result  output  WIDTH  registered result.
- flags  output  5  registered ZCFNL: [4]Z, [3]C, [2]F (overflow), [1]N, [0]L.
- busy  output  1  high while in the SHIFT state.

Behaviour:
- Reset, asynchronous on reset_n low:
  - state=IDLE; result=0; flags=0; out_valid=0; busy=0.
  - in_ready=0 while reset_n is low, 1 after release.
  - Reset asserted mid-operation abandons the operation; no partial result is ever presented.
- Opcodes:
  - NOP=0, AND=1, OR=2, XOR=3, NOT=4, ADD=5, ADDU=6, ADDC=7, SUB=9, CMP=11, LSH=12, RSH=13, ARSH=14, MUL=15 (optional).
  - Codes 8 and 10, and 15 when MUL is compiled out, are illegal.
- Accept: handshake fires when in_valid && in_ready.
- in_ready = (state==IDLE) && (!out_valid || out_ready).
- Single-cycle ops have latency 1: result, flags and out_valid are all registered on the cycle after accept.
- Output hold: result and flags hold while out_valid && !out_ready. out_valid clears on handshake unless a new result loads in the same cycle (back-to-back throughput of 1 per cycle).
- Flag rules (flags not listed are written 0):
  - AND/OR/XOR/NOT: Z only.
  - ADD: Z; F = signed overflow.
  - ADDU: Z; C = carry-out of bit WIDTH-1.
  - ADDC: result = a + b + C_prev, where C_prev is the registered C; Z, C and F all updated.
  - SUB: result = a - b; Z; C = borrow (a<b unsigned); F = (a[MSB]!=b[MSB]) && (result[MSB]!=a[MSB]).
  - CMP: result = 0; Z = (a==b); N = signed a<b; L = unsigned a<b.
  - Shifts: Z only.
- NOP: produces out_valid with result=0 and flags unchanged.
- Illegal op: result=0, flags unchanged.
- Shifts:
  - LSH: logical left. RSH: logical right. ARSH: arithmetic right (MSB replicated).
  - Amount n = b[SHW-1:0].
  - n=0: latency 1, result=a.
  - n>0: enter SHIFT, shift one bit per cycle, and assert out_valid on cycle n+1 after accept. busy=1 during SHIFT.
  - in_ready=0 throughout SHIFT.
- State machine:
  - IDLE: accept a shift with n>0 → SHIFT; accept anything else → stays IDLE and loads the output register.
  - SHIFT: count reaches 0 → IDLE, load output register.
  - MUL (optional feature only): count reaches 0 → IDLE, load output register.
- The output register must be free on the SHIFT→IDLE transition. This is guaranteed because acceptance required (!out_valid || out_ready), and the result of the previous op was drained before the shift started.

Optional Feature:
- SEQ_ALU_MUL_EN defined:
  - op 15 = unsigned shift-add multiply, low WIDTH bits of the product.
  - Latency WIDTH+1 cycles; busy=1 during the MUL state.
  - C = 1 if any high product bit is nonzero; Z set on a zero low word.
- SEQ_ALU_MUL_EN undefined: op 15 is illegal (result 0, flags unchanged); the MUL state does not exist.

Decomposition:
- Package alu_pkg holds:
  - 4-bit opcode localparams;
  - flag bit indices FLG_Z=4, FLG_C=3, FLG_F=2, FLG_N=1, FLG_L=0;
  - state encoding.
- Sub-module alu_shift_unit: iterative shifter. Ports: load, dir, arith, amount, data_in; outputs done and data_out.
- Logic ops, add/sub/compare and flag generation stay in seq_alu.

Test Plan:
- WIDTH=16: ADDU a=0xFFFF, b=0x0001 → result 0x0000, flags Z=1 C=1; then ADDC a=0x0001, b=0x0001 → result 0x0003, C=0.
- SUB a=0x8000, b=0x0001 → result 0x7FFF, F=1, C=0. CMP a=0xFFFF, b=0x0001 → N=1, L=0, Z=0, result 0.
- ARSH a=0x8010, b=4 → result 0xF801 with out_valid exactly 5 cycles after accept; in_ready=0 and busy=1 for those 4 shift cycles. LSH with b=0 → latency 1.
- Hold out_ready=0 for 3 cycles with an AND result pending → result and flags stable, in_ready=0; release → next op accepted in the same cycle the result drains.
- Assert reset_n low during a 15-bit LSH → out_valid, flags and result go to 0 immediately; first op after release completes normally.
- With SEQ_ALU_MUL_EN: MUL 0x0100 × 0x0100 → result 0x0000, Z=1, C=1 after 17 cycles. Without the macro, op 15 → result 0, flags unchanged.

Source files
------------

// File: rtl/alu_pkg.sv
// Opcodes, ZCFNL flag bit positions and state encoding shared by seq_alu and its shifter.
// The MUL state is only present when SEQ_ALU_MUL_EN is defined.
package alu_pkg;

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_AND  = 4'd1;
  localparam logic [3:0] OP_OR   = 4'd2;
  localparam logic [3:0] OP_XOR  = 4'd3;
  localparam logic [3:0] OP_NOT  = 4'd4;
  localparam logic [3:0] OP_ADD  = 4'd5;
  localparam logic [3:0] OP_ADDU = 4'd6;
  localparam logic [3:0] OP_ADDC = 4'd7;
  localparam logic [3:0] OP_SUB  = 4'd9;
  localparam logic [3:0] OP_CMP  = 4'd11;
  localparam logic [3:0] OP_LSH  = 4'd12;
  localparam logic [3:0] OP_RSH  = 4'd13;
  localparam logic [3:0] OP_ARSH = 4'd14;
  localparam logic [3:0] OP_MUL  = 4'd15;

  localparam int FLG_Z = 4;
  localparam int FLG_C = 3;
  localparam int FLG_F = 2;
  localparam int FLG_N = 1;
  localparam int FLG_L = 0;

`ifdef SEQ_ALU_MUL_EN
  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_MUL} state_e;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT} state_e;
`endif

endpackage

// File: rtl/alu_shift_unit.sv
// Iterative one-bit-per-cycle shifter. The first bit is shifted on load, so done rises
// in the cycle the n-th shifted value is held in data_out.
module alu_shift_unit #(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic             dir,
  input  logic             arith,
  input  logic [SHW-1:0]   amount,
  input  logic [WIDTH-1:0] data_in,
  output logic             done,
  output logic [WIDTH-1:0] data_out
);

  logic [WIDTH-1:0] data_q;
  logic [SHW-1:0]   cnt_q;
  logic             run_q, dir_q, arith_q;

  // dir=1 shifts right; arith replicates the MSB on right shifts
  function automatic logic [WIDTH-1:0] step1(input logic [WIDTH-1:0] d,
                                             input logic rt, input logic ar);
    if (rt) return {ar & d[WIDTH-1], d[WIDTH-1:1]};
    else    return {d[WIDTH-2:0], 1'b0};
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q  <= '0;
      cnt_q   <= '0;
      run_q   <= 1'b0;
      dir_q   <= 1'b0;
      arith_q <= 1'b0;
    end else if (load) begin
      data_q  <= step1(data_in, dir, arith);
      cnt_q   <= amount - SHW'(1);
      run_q   <= 1'b1;
      dir_q   <= dir;
      arith_q <= arith;
    end else if (run_q) begin
      if (cnt_q == '0) begin
        run_q <= 1'b0;
      end else begin
        data_q <= step1(data_q, dir_q, arith_q);
        cnt_q  <= cnt_q - SHW'(1);
      end
    end
  end

  assign done     = run_q && (cnt_q == '0);
  assign data_out = data_q;

endmodule

// File: rtl/seq_alu.sv
// Registered ALU with valid/ready handshake, persistent ZCFNL flags and iterative shifts.
// Define SEQ_ALU_MUL_EN to enable the shift-add multiplier on op 15.
module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [4:0]       flags,
  output logic             busy
);

  localparam int M = WIDTH - 1;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d, alu_res, sh_data, mul_res;
  logic [4:0]       flags_q, flags_d, alu_flg, mul_flg;
  logic             out_valid_q, out_valid_d;
  logic             accept, is_shift, sh_load, sh_done, mul_load, mul_done, z_upd;
  logic [WIDTH:0]   sum_ab, sum_abc, diff_ab;
  logic [SHW-1:0]   sh_amt;

  assign in_ready = reset_n && (state_q == ST_IDLE) && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign sh_amt   = b[SHW-1:0];
  assign is_shift = (op == OP_LSH) || (op == OP_RSH) || (op == OP_ARSH);
  assign sh_load  = accept && is_shift && (sh_amt != '0);

  assign sum_ab  = {1'b0, a} + {1'b0, b};
  assign sum_abc = sum_ab + {{WIDTH{1'b0}}, flags_q[FLG_C]};
  assign diff_ab = {1'b0, a} - {1'b0, b};

  alu_shift_unit #(.WIDTH(WIDTH), .SHW(SHW)) u_shift (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (sh_load),
    .dir      (op != OP_LSH),
    .arith    (op == OP_ARSH),
    .amount   (sh_amt),
    .data_in  (a),
    .done     (sh_done),
    .data_out (sh_data)
  );

`ifdef SEQ_ALU_MUL_EN
  logic [WIDTH-1:0]   mcand_q;
  logic [2*WIDTH-1:0] prod_q, prod_step;
  logic [SHW-1:0]     mul_cnt_q;
  logic [WIDTH:0]     mul_sum;

  // Right-shifting product register: high half accumulates, low half holds the multiplier
  assign mul_sum   = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
  assign prod_step = {mul_sum, prod_q[WIDTH-1:1]};
  assign mul_load  = accept && (op == OP_MUL);
  assign mul_done  = (state_q == ST_MUL) && (mul_cnt_q == '0);
  assign mul_res   = prod_step[WIDTH-1:0];
  assign mul_flg   = {(prod_step[WIDTH-1:0] == '0), |prod_step[2*WIDTH-1:WIDTH], 3'b000};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mcand_q   <= '0;
      prod_q    <= '0;
      mul_cnt_q <= '0;
    end else if (mul_load) begin
      mcand_q   <= a;
      prod_q    <= {{WIDTH{1'b0}}, b};
      mul_cnt_q <= SHW'(WIDTH - 1);
    end else if (state_q == ST_MUL) begin
      prod_q    <= prod_step;
      mul_cnt_q <= mul_cnt_q - SHW'(1);
    end
  end
`else
  assign mul_load = 1'b0;
  assign mul_done = 1'b0;
  assign mul_res  = '0;
  assign mul_flg  = '0;
`endif

  // Single-cycle result and flags; NOP and illegal codes keep the current flags
  always_comb begin
    alu_res = '0;
    alu_flg = '0;
    z_upd   = 1'b1;
    case (op)
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_XOR:  alu_res = a ^ b;
      OP_NOT:  alu_res = ~a;
      OP_ADD: begin
        alu_res        = sum_ab[M:0];
        alu_flg[FLG_F] = (a[M] == b[M]) && (alu_res[M] != a[M]);
      end
      OP_ADDU: begin
        alu_res        = sum_ab[M:0];
        alu_flg[FLG_C] = sum_ab[WIDTH];
      end
      OP_ADDC: begin
        alu_res        = sum_abc[M:0];
        alu_flg[FLG_C] = sum_abc[WIDTH];
        alu_flg[FLG_F] = (a[M] == b[M]) && (alu_res[M] != a[M]);
      end
      OP_SUB: begin
        alu_res        = diff_ab[M:0];
        alu_flg[FLG_C] = diff_ab[WIDTH];
        alu_flg[FLG_F] = (a[M] != b[M]) && (alu_res[M] != a[M]);
      end
      OP_CMP: begin
        z_upd          = 1'b0;
        alu_flg[FLG_Z] = (a == b);
        alu_flg[FLG_N] = $signed(a) < $signed(b);
        alu_flg[FLG_L] = a < b;
      end
      OP_LSH, OP_RSH, OP_ARSH: alu_res = a;
      default: begin
        z_upd   = 1'b0;
        alu_flg = flags_q;
      end
    endcase
    if (z_upd) alu_flg[FLG_Z] = (alu_res == '0);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (sh_load)       state_d = ST_SHIFT;
        else if (mul_load) state_d = state_e'(2);
      end
      ST_SHIFT: if (sh_done) state_d = ST_IDLE;
      default:  if (mul_done) state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != ST_IDLE);
  end

  // Output register: loaded by single-cycle accepts or when an iterative op finishes
  always_comb begin
    result_d    = result_q;
    flags_d     = flags_q;
    out_valid_d = out_valid_q && !out_ready;
    if (accept && !sh_load && !mul_load) begin
      result_d    = alu_res;
      flags_d     = alu_flg;
      out_valid_d = 1'b1;
    end else if (sh_done && (state_q == ST_SHIFT)) begin
      result_d    = sh_data;
      flags_d     = {(sh_data == '0), 4'b0000};
      out_valid_d = 1'b1;
    end else if (mul_done) begin
      result_d    = mul_res;
      flags_d     = mul_flg;
      out_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      result_q    <= '0;
      flags_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      result_q    <= result_d;
      flags_q     <= flags_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign flags     = flags_q;

endmodule

// File: tb/tb_seq_alu.sv
// Directed-vector bench for seq_alu (WIDTH=16); define SEQ_ALU_MUL_EN to cover the multiplier.
module tb_seq_alu;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  op = 4'd0;
  logic [15:0] a = 16'h0, b = 16'h0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] result;
  logic [4:0]  flags;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  seq_alu #(.WIDTH(16)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .flags(flags), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issue one op with out_ready=1, return latency (negedges from accept to out_valid)
  // and the number of cycles seen with busy=1 and in_ready=0 while waiting.
  task automatic do_op(input logic [3:0] o, input logic [15:0] aa, input logic [15:0] bb,
                       output int lat, output int busy_cyc);
    int t;
    @(negedge clk);
    in_valid = 1'b1; op = o; a = aa; b = bb;
    t = 0;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) check("accept_timeout", 0, 1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    busy_cyc = 0;
    while (!out_valid && lat < 100) begin
      if (busy && !in_ready) busy_cyc++;
      @(negedge clk);
      lat++;
    end
    if (lat >= 100) check("result_timeout", 0, 1);
    $display("op=%0d a=%h b=%h -> result=%h flags=%b lat=%0d", o, aa, bb, result, flags, lat);
  endtask

  initial begin
    int lat, bc;

    #2;
    check("rst_out_valid", out_valid, 0);
    check("rst_result", result, 0);
    check("rst_flags", flags, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1);

    do_op(4'd6, 16'hFFFF, 16'h0001, lat, bc);
    check("addu_res", result, 16'h0000);
    check("addu_flg", flags, 5'b11000);
    check("addu_lat", lat, 1);

    do_op(4'd7, 16'h0001, 16'h0001, lat, bc);
    check("addc_res", result, 16'h0003);
    check("addc_flg", flags, 5'b00000);

    do_op(4'd9, 16'h8000, 16'h0001, lat, bc);
    check("sub_res", result, 16'h7FFF);
    check("sub_flg", flags, 5'b00100);

    do_op(4'd11, 16'hFFFF, 16'h0001, lat, bc);
    check("cmp_res", result, 16'h0000);
    check("cmp_flg", flags, 5'b00010);

    do_op(4'd0, 16'h1234, 16'h5678, lat, bc);
    check("nop_res", result, 16'h0000);
    check("nop_flg", flags, 5'b00010);

    do_op(4'd8, 16'h1234, 16'h5678, lat, bc);
    check("ill8_res", result, 16'h0000);
    check("ill8_flg", flags, 5'b00010);

    do_op(4'd15, 16'h0100, 16'h0100, lat, bc);
    check("op15_res", result, 16'h0000);
`ifdef SEQ_ALU_MUL_EN
    check("mul_flg", flags, 5'b11000);
    check("mul_lat", lat, 17);
    check("mul_busy", bc, 16);
`else
    check("ill15_flg", flags, 5'b00010);
    check("ill15_lat", lat, 1);
`endif

    do_op(4'd14, 16'h8010, 16'h0004, lat, bc);
    check("arsh_res", result, 16'hF801);
    check("arsh_flg", flags, 5'b00000);
    check("arsh_lat", lat, 5);
    check("arsh_busy", bc, 4);

    do_op(4'd12, 16'h00A5, 16'h0000, lat, bc);
    check("lsh0_res", result, 16'h00A5);
    check("lsh0_lat", lat, 1);

    do_op(4'd13, 16'h8000, 16'h000F, lat, bc);
    check("rsh15_res", result, 16'h0001);
    check("rsh15_lat", lat, 16);

    // Back-pressure: AND result held while out_ready=0
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b1; op = 4'd1; a = 16'hF0F0; b = 16'h0FF0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check("hold_valid0", out_valid, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("hold_res", result, 16'h00F0);
      check("hold_flg", flags, 5'b00000);
      check("hold_in_ready", in_ready, 0);
      check("hold_valid", out_valid, 1);
    end
    $display("op=1 a=f0f0 b=0ff0 -> result=%h flags=%b held 3 cycles", result, flags);
    out_ready = 1'b1;
    in_valid = 1'b1; op = 4'd3; a = 16'h5A5A; b = 16'h5A5A;
    #1;
    check("drain_in_ready", in_ready, 1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check("b2b_valid", out_valid, 1);
    check("b2b_res", result, 16'h0000);
    check("b2b_flg", flags, 5'b10000);
    $display("op=3 a=5a5a b=5a5a -> result=%h flags=%b back-to-back", result, flags);

    do_op(4'd6, 16'hFFFF, 16'h0002, lat, bc);
    check("addu2_res", result, 16'h0001);
    check("addu2_flg", flags, 5'b01000);

    // Reset in the middle of a 15-bit LSH
    @(negedge clk);
    in_valid = 1'b1; op = 4'd12; a = 16'h0001; b = 16'h000F;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_busy", busy, 1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_res", result, 0);
    check("mid_rst_flg", flags, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_in_ready", in_ready, 0);
    $display("reset during LSH a=0001 b=000f -> result=%h flags=%b", result, flags);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    do_op(4'd5, 16'h7FFF, 16'h0001, lat, bc);
    check("post_add_res", result, 16'h8000);
    check("post_add_flg", flags, 5'b00100);
    check("post_add_lat", lat, 1);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got 0x0 expected 0x1");
    $fatal(1, "timeout");
  end

endmodule
